message_stream_arbiter: RTL and testbench

MESSAGE_STREAM_ARBITER -- requirements
Module: message_stream_arbiter

---
 rtl/message_stream_arbiter.sv | 158 +++++++++++++++
 tb/tb_message_stream_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_stream_arbiter.sv
// Merges N per-stream packet FIFOs onto one output, packet at a time.
// Round-robin or fixed-priority grant; sticky overflow/error flags.
module message_stream_arbiter #(
  parameter int N_STREAMS               = 4,
  parameter int LOG_N_STREAMS           = 2,
  parameter int WIDTH                   = 32,
  parameter int INPUT_BUFFER_LENGTH     = 16,
  parameter int LOG_INPUT_BUFFER_LENGTH = 4,
  parameter int MAX_PACKET_LENGTH       = 8,
  parameter int LOG_MAX_PACKET_LENGTH   = 3,
  parameter int PRIORITY_MODE           = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH*N_STREAMS-1:0] in_data,
  input  logic [N_STREAMS-1:0]       in_nd,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_nd,
  output logic [LOG_N_STREAMS-1:0]   out_stream,
  output logic [N_STREAMS-1:0]       overflow,
  output logic                       error
);

  localparam int PW = LOG_INPUT_BUFFER_LENGTH;
  localparam int GW = LOG_N_STREAMS;
  localparam int LW = LOG_MAX_PACKET_LENGTH;
  localparam int CW = LOG_MAX_PACKET_LENGTH + 1;
  localparam logic [CW-1:0] MAX_L = CW'(MAX_PACKET_LENGTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state, state_n;
  logic [GW-1:0]  grant, grant_n;
  logic [GW-1:0]  last_grant, last_n;
  logic [CW-1:0]  rem, rem_n;
  logic           ready_q;

  logic [N_STREAMS-1:0] empty, full, wr_en, rd_en, drop;
  logic [WIDTH-1:0]     head [N_STREAMS];

  logic           bad;
  logic           rd_word;
  logic [GW-1:0]  sel;
  logic           sel_ok;
  logic [LW-1:0]  hd_len;
  int             j;

  for (genvar k = 0; k < N_STREAMS; k++) begin : g_fifo
    logic [WIDTH-1:0] mem [INPUT_BUFFER_LENGTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      cnt;

    assign empty[k] = (cnt == '0);
    assign full[k]  = (cnt == (PW+1)'(INPUT_BUFFER_LENGTH));
    assign head[k]  = mem[rd_ptr];
    // A full FIFO still takes the word if it is also popped this cycle.
    assign wr_en[k] = rst_n & in_nd[k] & (~full[k] | rd_en[k]);
    assign drop[k]  = rst_n & in_nd[k] & full[k] & ~rd_en[k];

    always_ff @(posedge clk) begin
      if (wr_en[k]) mem[wr_ptr] <= in_data[WIDTH*k +: WIDTH];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_en[k]) wr_ptr <= wr_ptr + PW'(1);
        if (rd_en[k]) rd_ptr <= rd_ptr + PW'(1);
        if (wr_en[k] && !rd_en[k])      cnt <= cnt + (PW+1)'(1);
        else if (!wr_en[k] && rd_en[k]) cnt <= cnt - (PW+1)'(1);
      end
    end
  end

  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    j      = 0;
    for (int i = 0; i < N_STREAMS; i++) begin
      if (PRIORITY_MODE != 0) j = i;
      else j = (int'(last_grant) + 1 + i) % N_STREAMS;
      if (!sel_ok && !empty[j]) begin
        sel_ok = 1'b1;
        sel    = GW'(j);
      end
    end
  end

  assign hd_len = head[sel][LW-1:0];

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last_grant;
    rem_n   = rem;
    rd_en   = '0;
    bad     = 1'b0;
    rd_word = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_ok) begin
          // Malformed heads are popped here so they never reach the output.
          if (!head[sel][WIDTH-1] || ({1'b0, hd_len} > MAX_L)) begin
            rd_en[sel] = 1'b1;
            bad        = 1'b1;
          end else begin
            grant_n = sel;
            last_n  = sel;
            rem_n   = {1'b0, hd_len} + CW'(1);
            state_n = SEND;
          end
        end
      end
      SEND: begin
        if (!empty[grant] && ready_q) begin
          rd_en[grant] = 1'b1;
          rd_word      = 1'b1;
          rem_n        = rem - CW'(1);
          if (rem == CW'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(N_STREAMS - 1);
      rem        <= '0;
      ready_q    <= 1'b0;
      out_data   <= '0;
      out_nd     <= 1'b0;
      out_stream <= '0;
      overflow   <= '0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_n;
      rem        <= rem_n;
      ready_q    <= out_ready;
      out_nd     <= rd_word;
      if (rd_word) begin
        out_data   <= head[grant];
        out_stream <= grant;
      end
      overflow   <= overflow | drop;
      error      <= error | (|drop) | bad;
    end
  end

endmodule

// File: tb/tb_message_stream_arbiter.sv
// Directed bench for message_stream_arbiter with an output scoreboard.
// A second instance in fixed-priority mode shares the same stimulus.
module tb_message_stream_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_nd = '0;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data, fp_data;
  logic         out_nd, fp_nd;
  logic [1:0]   out_stream, fp_stream;
  logic [3:0]   overflow, fp_ovf;
  logic         error, fp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [33:0] sb [$];
  int          out_cyc [$];
  logic [1:0]  fp_log [$];
  logic [33:0] exp_w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  message_stream_arbiter #(
    .N_STREAMS(4), .LOG_N_STREAMS(2), .WIDTH(32),
    .INPUT_BUFFER_LENGTH(16), .LOG_INPUT_BUFFER_LENGTH(4),
    .MAX_PACKET_LENGTH(8), .LOG_MAX_PACKET_LENGTH(4),
    .PRIORITY_MODE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd),
    .out_ready(out_ready), .out_data(out_data), .out_nd(out_nd),
    .out_stream(out_stream), .overflow(overflow), .error(error)
  );

  message_stream_arbiter #(
    .N_STREAMS(4), .LOG_N_STREAMS(2), .WIDTH(32),
    .INPUT_BUFFER_LENGTH(16), .LOG_INPUT_BUFFER_LENGTH(4),
    .MAX_PACKET_LENGTH(8), .LOG_MAX_PACKET_LENGTH(4),
    .PRIORITY_MODE(1)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd),
    .out_ready(out_ready), .out_data(fp_data), .out_nd(fp_nd),
    .out_stream(fp_stream), .overflow(fp_ovf), .error(fp_err)
  );

  always @(posedge clk) begin
    #1;
    if (out_nd === 1'b1) begin
      out_cyc.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected_out obs=%h exp=none", {out_stream, out_data});
      end else begin
        exp_w = sb.pop_front();
        assert ({out_stream, out_data} === exp_w) else begin
          errors++;
          $error("FAIL out_word obs=%h exp=%h", {out_stream, out_data}, exp_w);
        end
      end
    end
    if (fp_nd === 1'b1) fp_log.push_back(fp_stream);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] hdr(input int len, input int tag);
    return 32'h8000_0000 | ((tag & 32'hff) << 8) | (len & 32'hf);
  endfunction

  function automatic logic [31:0] pl(input int tag, input int i);
    return ((tag & 32'hff) << 16) | (i & 32'hff);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] nd, input logic [127:0] d);
    @(negedge clk);
    in_nd   = nd;
    in_data = d;
  endtask

  task automatic put(input int k, input logic [31:0] w);
    logic [127:0] d;
    d = '0;
    d[k*32 +: 32] = w;
    drive(4'b0001 << k, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_nd = '0;
    end
  endtask

  task automatic expect_w(input int k, input logic [31:0] w);
    sb.push_back({2'(k), w});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_nd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    out_cyc.delete();
    fp_log.delete();
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    idle(4);
  endtask

  task automatic wait_outs(input int cnt);
    int n;
    n = 0;
    while (out_cyc.size() < cnt && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("outs_seen", (out_cyc.size() >= cnt), 1);
  endtask

  initial begin
    logic [127:0] d;
    int c0;
    logic [1:0] fp_exp [8];

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nd", out_nd, 0);
    chk("rst_data", out_data, 0);
    chk("rst_stream", out_stream, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // streams 0 and 2, L=2 each
    for (int i = 0; i < 3; i++) begin
      d = '0;
      d[31:0]  = (i == 0) ? hdr(2, 8'h10) : pl(8'h10, i);
      d[95:64] = (i == 0) ? hdr(2, 8'h12) : pl(8'h12, i);
      drive(4'b0101, d);
    end
    for (int i = 0; i < 3; i++)
      expect_w(0, (i == 0) ? hdr(2, 8'h10) : pl(8'h10, i));
    for (int i = 0; i < 3; i++)
      expect_w(2, (i == 0) ? hdr(2, 8'h12) : pl(8'h12, i));
    idle(1);
    out_ready = 1'b1;
    wait_drain(60);
    chk("t1_count", out_cyc.size(), 6);
    chk("t1_b2b_a", out_cyc[1] - out_cyc[0], 1);
    chk("t1_b2b_b", out_cyc[2] - out_cyc[1], 1);
    chk("t1_gap", out_cyc[3] - out_cyc[2], 2);
    chk("t1_b2b_c", out_cyc[5] - out_cyc[4], 1);

    // minimum latency from idle
    out_cyc.delete();
    put(1, hdr(0, 8'h11));
    c0 = cyc;
    expect_w(1, hdr(0, 8'h11));
    idle(1);
    wait_drain(30);
    chk("latency", out_cyc[0] - c0, 3);

    // round-robin vs fixed priority, L=0 packets on all streams
    do_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      d = '0;
      for (int k = 0; k < 4; k++) d[k*32 +: 32] = hdr(0, k*16 + r);
      drive(4'hF, d);
    end
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) expect_w(k, hdr(0, k*16 + r));
    idle(1);
    out_ready = 1'b1;
    wait_drain(80);
    idle(6);
    fp_exp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    chk("fp_count", fp_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("fp_grant%0d", i), fp_log[i], fp_exp[i]);

    // overflow: 17 words into stream 1 while stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 0)       put(1, hdr(7, 8'h31));
      else if (i < 8)   put(1, pl(8'h31, i));
      else if (i == 8)  put(1, hdr(7, 8'h32));
      else if (i < 16)  put(1, pl(8'h32, i));
      else              put(1, pl(8'h33, 0));
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      expect_w(1, hdr(7, 8'h31));
      else if (i < 8)  expect_w(1, pl(8'h31, i));
      else if (i == 8) expect_w(1, hdr(7, 8'h32));
      else             expect_w(1, pl(8'h32, i));
    end
    idle(2);
    chk("ovf_flags", overflow, 4'b0010);
    chk("ovf_err", error, 1);
    chk("ovf_no_out", out_cyc.size(), 0);
    out_ready = 1'b1;
    wait_drain(120);
    idle(6);
    chk("ovf_sticky", overflow, 4'b0010);

    // out_ready low for 5 cycles mid-packet
    do_reset();
    out_ready = 1'b0;
    put(2, hdr(6, 8'h40));
    expect_w(2, hdr(6, 8'h40));
    for (int i = 1; i <= 6; i++) begin
      put(2, pl(8'h40, i));
      expect_w(2, pl(8'h40, i));
    end
    idle(1);
    out_ready = 1'b1;
    wait_outs(3);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_nd", out_nd, 0);
      if (i == 3) begin
        @(negedge clk);
        out_ready = 1'b1;
      end
    end
    wait_drain(60);
    chk("stall_total", out_cyc.size(), 7);

    // malformed heads: bit31 clear, then L above maximum
    do_reset();
    out_ready = 1'b1;
    put(3, 32'h0000_0005);
    put(3, hdr(1, 8'h51));
    put(3, pl(8'h51, 1));
    expect_w(3, hdr(1, 8'h51));
    expect_w(3, pl(8'h51, 1));
    idle(1);
    wait_drain(40);
    chk("bad31_err", error, 1);
    chk("bad31_ovf", overflow, 0);
    do_reset();
    chk("err_cleared", error, 0);
    put(3, 32'h8000_0009);
    put(3, hdr(0, 8'h52));
    expect_w(3, hdr(0, 8'h52));
    idle(1);
    wait_drain(40);
    chk("badlen_err", error, 1);

    // reset in the middle of an L=6 packet
    do_reset();
    out_ready = 1'b1;
    put(0, hdr(6, 8'h60));
    expect_w(0, hdr(6, 8'h60));
    for (int i = 1; i <= 6; i++) begin
      put(0, pl(8'h60, i));
      expect_w(0, pl(8'h60, i));
    end
    idle(1);
    wait_outs(2);
    @(negedge clk);
    rst_n = 1'b0;
    d = '0;
    d[63:32] = hdr(0, 8'h61);
    in_data = d;
    in_nd = 4'b0010;
    sb.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_nd", out_nd, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_stream", out_stream, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_err", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_nd = '0;
    idle(20);
    put(0, hdr(0, 8'h62));
    expect_w(0, hdr(0, 8'h62));
    idle(1);
    wait_drain(40);
    chk("post_rst_err", error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
